channel_fifo: RTL and testbench
===============================

// Module: channel_fifo
// PURPOSE
//   Storage side of the ac_channel port protocol used by generated kernels.
//   Kernels such as reduce, map and stream consumers are the clients of this channel.
//   Producers push with write_valid/write_ready/in_data.
//   Consumers pop with read_valid/read_ready/out_data.
//   Buffers up to DEPTH words between a producer kernel and a consumer kernel.
// PARAMETERS
//   WIDTH  32  data word width in bits
//   DEPTH  8   entries; power of 2, >= 2
//   AW     3   pointer width = log2(DEPTH); must match DEPTH
// PORTS
//   clk          in   1         single clock, all state on rising edge
//   rst          in   1         synchronous, active-high reset
//   in_data      in   WIDTH     write word, sampled when a push occurs
//   write_valid  in   1         producer requests push this cycle
//   write_ready  out  1         channel can accept a word (not full)
//   read_valid   in   1         consumer requests pop this cycle
//   read_ready   out  1         channel holds at least one word (not empty)
//   out_data     out  WIDTH     registered word from the most recent pop
//   count        out  AW+1      current occupancy, 0..DEPTH
//   err          out  1         sticky protocol-error flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=1 at an edge)
//     - rd_ptr, wr_ptr, count, out_data and err all go to 0.
//     - Any in-flight contents are discarded; mid-operation reset is a full flush.
//     - write_ready=0 and read_ready=0 while rst is high.
//   Ready outputs (combinational from registered state only, no comb path from valid)
//     - write_ready = !rst && count != DEPTH.
//     - read_ready = !rst && count != 0.
//   Push = write_valid && write_ready
//     - mem[wr_ptr] <= in_data; wr_ptr increments modulo DEPTH (natural AW-bit wrap).
//   Pop = read_valid && read_ready
//     - out_data <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
//     - out_data holds its value until the next pop; it never changes otherwise.
//     - Matches the client sequence: wait read_ready, pulse read_valid for one cycle,
//       sample out_data in the following cycle.
//   Count update
//     - push only: +1. pop only: -1. Both or neither: unchanged.
//   Latency
//     - A word pushed at edge N gives read_ready=1 from cycle N+1.
//     - Popping at edge N+1 gives out_data=word from cycle N+2.
//     - No fall-through: an empty channel cannot pop in the cycle of its first push.
//   Boundary cases
//     - Full with simultaneous valids: pop occurs, push is refused because write_ready=0.
//       Next cycle count=DEPTH-1 and write_ready=1.
//     - Empty with simultaneous valids: push occurs, pop is refused.
//     - write_valid when full or read_valid when empty is ignored; no state change.
//     - Ordering is strictly FIFO across pointer wrap-around.
// CONFIGURATION
//   CHANNEL_FIFO_ERR_EN defined
//     - err <= 1 on any edge where (write_valid && count==DEPTH)
//       or (read_valid && count==0).
//     - err stays high until rst.
//   CHANNEL_FIFO_ERR_EN undefined
//     - err is tied to 0 and no error-detection logic is built.
//     - All other behaviour is identical.
// TESTING
//   1. Reset, then idle: count=0, read_ready=0, write_ready=1, out_data=0, err=0.
//   2. Push 5,7,9,11 on consecutive cycles, then pop 4 times with a one-cycle pulse
//      after each read_ready -> out_data=5,7,9,11 in order; count ends at 0.
//   3. Push 8 words 1..8: write_ready drops after the 8th (count=8).
//      A 9th push of 99 is ignored.
//      With ERR_EN: err=1. Without it: err=0.
//   4. When full, assert write_valid(in_data=42) and read_valid together -> out_data=1,
//      count=7, 42 not stored. Then push 42 and pop 8 times -> 2..8,42.
//   5. Run 20 words through with interleaved push/pop (count in 1..3)
//      -> output order equals input order across pointer wrap.
//   6. Assert rst with count=4 -> next cycle count=0, read_ready=0, out_data=0.
//      A subsequent push of 0xDEADBEEF followed by a pop -> out_data=0xDEADBEEF.

Source files
------------

// File: rtl/channel_fifo.sv
// Registered-output FIFO for the ac_channel push/pop protocol, DEPTH words of WIDTH bits.
// Optional sticky protocol-error detection is built when CHANNEL_FIFO_ERR_EN is defined.
module channel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             write_valid,
  output logic             write_ready,
  input  logic             read_valid,
  output logic             read_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      count,
  output logic             err
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Readies depend only on registered state so clients never see a loop through valid.
  assign write_ready = !rst && (count != FULL_COUNT);
  assign read_ready  = !rst && (count != '0);
  assign push        = write_valid && write_ready;
  assign pop         = read_valid && read_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

`ifdef CHANNEL_FIFO_ERR_EN
  // Sticky until reset: flags a request made against a full or empty channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((write_valid && count == FULL_COUNT) || (read_valid && count == '0)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_channel_fifo.sv
// Directed bench for channel_fifo: a scoreboard queue holds expected pop data,
// a monitor compares out_data the cycle after each accepted pop.
module tb_channel_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        write_valid;
  logic        write_ready;
  logic        read_valid;
  logic        read_ready;
  logic [31:0] out_data;
  logic [3:0]  count;
  logic        err;

  int          checks;
  int          errors;
  logic [31:0] exp_q[$];
  logic [31:0] model_q[$];

  channel_fifo #(.WIDTH(32), .DEPTH(8), .AW(3)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .write_valid(write_valid),
    .write_ready(write_ready),
    .read_valid(read_valid),
    .read_ready(read_ready),
    .out_data(out_data),
    .count(count),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Called at a falling edge: drives one cycle of inputs, updates the reference contents,
  // and returns at the next falling edge with inputs released.
  task automatic applyStimulus(input logic wv, input logic [31:0] d, input logic rv);
    logic push_ok;
    logic pop_ok;
    push_ok = wv && (model_q.size() != 8);
    pop_ok  = rv && (model_q.size() != 0);
    write_valid = wv;
    in_data     = d;
    read_valid  = rv;
    if (pop_ok) exp_q.push_back(model_q.pop_front());
    if (push_ok) model_q.push_back(d);
    @(negedge clk);
    write_valid = 1'b0;
    read_valid  = 1'b0;
    in_data     = '0;
  endtask

  task automatic popWhenReady(input string name);
    int waited;
    waited = 0;
    while (!read_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!read_ready) begin
      checkOutput({name, "_ready_timeout"}, 32'(read_ready), 32'd1);
    end else begin
      applyStimulus(1'b0, 32'd0, 1'b1);
      @(negedge clk);
    end
  endtask

  // Monitor: an accepted pop at a rising edge shows its word on out_data after that edge.
  always @(posedge clk) begin
    if (!rst && read_valid && read_ready) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checkOutput("scoreboard_underflow", out_data, 32'hFFFF_FFFF);
      end else begin
        checkOutput("pop_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    write_valid = 1'b0;
    read_valid  = 1'b0;
    in_data     = '0;

    // Test 1: reset then idle
    @(negedge clk);
    checkOutput("rst_write_ready", 32'(write_ready), 32'd0);
    checkOutput("rst_read_ready", 32'(read_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_count", 32'(count), 32'd0);
    checkOutput("idle_read_ready", 32'(read_ready), 32'd0);
    checkOutput("idle_write_ready", 32'(write_ready), 32'd1);
    checkOutput("idle_out_data", out_data, 32'd0);
    checkOutput("idle_err", 32'(err), 32'd0);

    // Test 2: push 5,7,9,11 then pop four times
    applyStimulus(1'b1, 32'd5, 1'b0);
    checkOutput("first_push_read_ready", 32'(read_ready), 32'd1);
    applyStimulus(1'b1, 32'd7, 1'b0);
    applyStimulus(1'b1, 32'd9, 1'b0);
    applyStimulus(1'b1, 32'd11, 1'b0);
    checkOutput("t2_count_full4", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) popWhenReady("t2_pop");
    checkOutput("t2_last_out", out_data, 32'd11);
    checkOutput("t2_count_end", 32'(count), 32'd0);

    // Test 3: fill to 8, ninth push is ignored
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 32'(i), 1'b0);
    checkOutput("t3_count_full", 32'(count), 32'd8);
    checkOutput("t3_write_ready_full", 32'(write_ready), 32'd0);
    applyStimulus(1'b1, 32'd99, 1'b0);
    checkOutput("t3_count_after_99", 32'(count), 32'd8);
`ifdef CHANNEL_FIFO_ERR_EN
    checkOutput("t3_err", 32'(err), 32'd1);
`else
    checkOutput("t3_err", 32'(err), 32'd0);
`endif

    // Test 4: full with both valids, then drain through wrap
    applyStimulus(1'b1, 32'd42, 1'b1);
    checkOutput("t4_out_data", out_data, 32'd1);
    checkOutput("t4_count", 32'(count), 32'd7);
    checkOutput("t4_write_ready", 32'(write_ready), 32'd1);
    applyStimulus(1'b1, 32'd42, 1'b0);
    checkOutput("t4_count_refill", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) popWhenReady("t4_pop");
    checkOutput("t4_last_out", out_data, 32'd42);
    checkOutput("t4_count_end", 32'(count), 32'd0);

    // Empty with both valids: push taken, pop refused
    applyStimulus(1'b1, 32'd77, 1'b1);
    checkOutput("empty_both_count", 32'(count), 32'd1);
    checkOutput("empty_both_out_unchanged", out_data, 32'd42);
    popWhenReady("empty_both_pop");

    // Test 5: 20 words interleaved, occupancy stays within 1..3
    applyStimulus(1'b1, 32'd100, 1'b0);
    applyStimulus(1'b1, 32'd101, 1'b0);
    for (int i = 2; i < 20; i++) begin
      applyStimulus(1'b1, 32'(100 + i), 1'b1);
      if (i % 5 == 0) applyStimulus(1'b1, 32'(1000 + i), 1'b1);
    end
    checkOutput("t5_count", 32'(count), 32'd2);
    popWhenReady("t5_pop");
    popWhenReady("t5_pop");
    checkOutput("t5_last_out", out_data, 32'd119);
    checkOutput("t5_count_end", 32'(count), 32'd0);

    // Test 6: mid-operation reset flushes contents
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(200 + i), 1'b0);
    checkOutput("t6_count_before", 32'(count), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    checkOutput("t6_count_after_rst", 32'(count), 32'd0);
    checkOutput("t6_read_ready_after_rst", 32'(read_ready), 32'd0);
    checkOutput("t6_out_after_rst", out_data, 32'd0);
    checkOutput("t6_err_after_rst", 32'(err), 32'd0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
    popWhenReady("t6_pop");
    checkOutput("t6_out_deadbeef", out_data, 32'hDEAD_BEEF);
    checkOutput("t6_err_end", 32'(err), 32'd0);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
